// File: rtl/clock_enable_sync.sv
// Turns an asynchronous divided clock into clk_src-domain rise/fall/prescale enables.
// Define CLOCK_ENABLE_SYNC_WATCHDOG_EN to add the lock/loss watchdog.
module clock_enable_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned PRESCALE    = 16,
    parameter int unsigned TIMEOUT     = 64,
    parameter int unsigned LOCK_EDGES  = 4
) (
    input  logic        clk_src,
    input  logic        reset_n,
    input  logic        clk_div,
    output logic        en_rise,
    output logic        en_fall,
    output logic        en_pre,
    output logic        locked,
    output logic        lost,
    output logic [15:0] edge_count
);

    localparam int unsigned PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned ARM_W    = 3;
    localparam int unsigned ARM_DONE = SYNC_STAGES + 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

    // Elaboration-time parameter range checks
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("SYNC_STAGES must be 2..4");
    end
    if (PRESCALE < 1 || PRESCALE > 256) begin : g_bad_pre
        $error("PRESCALE must be 1..256");
    end
    if (TIMEOUT < 4 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("TIMEOUT must be 4..65535");
    end
    if (LOCK_EDGES < 1 || LOCK_EDGES > 255) begin : g_bad_lock
        $error("LOCK_EDGES must be 1..255");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic [ARM_W-1:0]       arm_q;
    logic [PRE_W-1:0]       pre_q;
    logic                   sync_last_c;
    logic                   armed_c;
    logic                   rise_c;
    logic                   fall_c;
    logic                   pre_clr_c;
    logic [PRE_W-1:0]       pre_base_c;
    logic                   pre_wrap_c;

    assign sync_last_c = sync_q[SYNC_STAGES-1];
    // Detection stays off until the history flop holds a value loaded from a full chain,
    // so a clk_div already high at reset release is never seen as a rising edge.
    assign armed_c     = (arm_q == ARM_W'(ARM_DONE));
    assign rise_c      = armed_c &  sync_last_c & ~hist_q;
    assign fall_c      = armed_c & ~sync_last_c &  hist_q;
    assign pre_base_c  = pre_clr_c ? '0 : pre_q;
    assign pre_wrap_c  = (pre_base_c == PRE_MAX);

    // Synchroniser, history flop and registered edge enables
    always_ff @(posedge clk_src or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            hist_q  <= 1'b0;
            arm_q   <= '0;
            en_rise <= 1'b0;
            en_fall <= 1'b0;
            en_pre  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], clk_div};
            hist_q  <= sync_last_c;
            if (!armed_c) begin
                arm_q <= arm_q + ARM_W'(1);
            end
            en_rise <= rise_c;
            en_fall <= fall_c;
            en_pre  <= rise_c & pre_wrap_c;
        end
    end

    // Prescale counter; a clear on loss entry coinciding with a rise counts that rise first
    always_ff @(posedge clk_src or negedge reset_n) begin
        if (!reset_n) begin
            pre_q <= '0;
        end else if (rise_c) begin
            pre_q <= pre_wrap_c ? '0 : pre_base_c + PRE_W'(1);
        end else begin
            pre_q <= pre_base_c;
        end
    end

    // Rising-edge counter trails en_rise by one cycle and wraps silently
    always_ff @(posedge clk_src or negedge reset_n) begin
        if (!reset_n) begin
            edge_count <= '0;
        end else if (en_rise) begin
            edge_count <= edge_count + 16'd1;
        end
    end

`ifdef CLOCK_ENABLE_SYNC_WATCHDOG_EN
    localparam int unsigned LOCK_W = 8;
    localparam logic [CNT_W-1:0]  TIMEOUT_V = CNT_W'(TIMEOUT);
    localparam logic [LOCK_W-1:0] LOCK_V    = LOCK_W'(LOCK_EDGES);
    localparam logic [LOCK_W-1:0] LOCK_SAT  = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOCKING = 2'd1,
        LOCKED  = 2'd2,
        LOST    = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_nxt;
    logic [CNT_W-1:0]   idle_q;
    logic [LOCK_W-1:0]  lock_q;
    logic [LOCK_W-1:0]  lock_nxt;
    logic               edge_c;
    logic               timeout_c;

    assign edge_c    = en_rise | en_fall;
    // An edge in the same cycle as the timeout wins
    assign timeout_c = !edge_c && (idle_q == TIMEOUT_V);
    assign pre_clr_c = (state_nxt == LOST) && (state_q != LOST);

    // Idle counter: cycles since the last edge, saturating at TIMEOUT
    always_ff @(posedge clk_src or negedge reset_n) begin
        if (!reset_n) begin
            idle_q <= '0;
        end else if (edge_c) begin
            idle_q <= '0;
        end else if (idle_q != TIMEOUT_V) begin
            idle_q <= idle_q + CNT_W'(1);
        end
    end

    // Watchdog state register and registered status flags
    always_ff @(posedge clk_src or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            lock_q  <= '0;
            locked  <= 1'b0;
            lost    <= 1'b0;
        end else begin
            state_q <= state_nxt;
            lock_q  <= lock_nxt;
            locked  <= (state_nxt == LOCKED);
            lost    <= (state_nxt == LOST);
        end
    end

    // Next-state logic; lock_q counts consecutive rises since leaving IDLE or LOST
    always_comb begin
        state_nxt = state_q;
        lock_nxt  = lock_q;
        case (state_q)
            IDLE: begin
                if (en_rise) begin
                    state_nxt = LOCKING;
                    lock_nxt  = LOCK_W'(1);
                end
            end
            LOCKING: begin
                if (timeout_c) begin
                    state_nxt = LOST;
                    lock_nxt  = '0;
                end else begin
                    if (en_rise && lock_q != LOCK_SAT) begin
                        lock_nxt = lock_q + LOCK_W'(1);
                    end
                    if (lock_nxt >= LOCK_V) begin
                        state_nxt = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (timeout_c) begin
                    state_nxt = LOST;
                    lock_nxt  = '0;
                end
            end
            LOST: begin
                if (en_rise) begin
                    state_nxt = LOCKING;
                    lock_nxt  = LOCK_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                lock_nxt  = '0;
            end
        endcase
    end
`else
    assign pre_clr_c = 1'b0;
    assign locked    = 1'b1;
    assign lost      = 1'b0;
`endif

endmodule

// File: doc/clock_enable_sync.md
CLOCK_ENABLE_SYNC -- requirements
Module: clock_enable_sync

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchroniser flops on clk_div (legal 2..4).
REQ-002 SHALL have parameter PRESCALE, default 16, rising edges of clk_div per en_pre pulse (legal 1..256).
REQ-003 SHALL have parameter TIMEOUT, default 64, clk_src cycles without any clk_div edge before loss is declared (legal 4..65535).
REQ-004 SHALL have parameter LOCK_EDGES, default 4, consecutive rising edges needed to declare lock (legal 1..255).
REQ-005 clk_src  input  1  system clock; all logic on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 clk_div  input  1  divided clock from the differential divider; treated as asynchronous.
REQ-008 en_rise  output 1  one-cycle pulse per synchronised clk_div rising edge.
REQ-009 en_fall  output 1  one-cycle pulse per synchronised clk_div falling edge.
REQ-010 en_pre   output 1  one-cycle pulse on every PRESCALE-th en_rise.
REQ-011 locked   output 1  high while clk_div is judged stable.
REQ-012 lost     output 1  high while clk_div is judged absent.
REQ-013 edge_count output 16  count of rising edges since reset.

Function
REQ-014 clk_div SHALL pass through SYNC_STAGES flops, then one history flop; edge detect compares last sync flop against history flop.
REQ-015 en_rise/en_fall SHALL be registered; a clk_div transition first sampled at clk_src edge k SHALL produce its pulse high during cycle k+SYNC_STAGES+1 only.
REQ-016 en_rise and en_fall SHALL never be high in the same cycle; each SHALL be high for exactly one clk_src cycle per edge.
REQ-017 Prescale counter SHALL be ceil(log2(PRESCALE))-bit min 1, increment on en_rise, wrap PRESCALE-1 -> 0.
REQ-018 en_pre SHALL be high in the same cycle as the en_rise that wraps the counter; PRESCALE=1 SHALL make en_pre identical to en_rise.
REQ-019 edge_count SHALL increment one cycle after each en_rise and wrap 0xFFFF -> 0x0000 with no flag.
REQ-020 Watchdog idle counter SHALL clear on any en_rise or en_fall, else increment, saturating at TIMEOUT.
REQ-021 Watchdog FSM states IDLE, LOCKING, LOCKED, LOST; IDLE after reset.
REQ-022 IDLE -> LOCKING on first en_rise; idle counter not evaluated in IDLE.
REQ-023 LOCKING -> LOCKED when consecutive rising-edge count reaches LOCK_EDGES; LOCK_EDGES=1 locks on the edge that leaves IDLE's successor count of 1.
REQ-024 LOCKING or LOCKED -> LOST when idle counter reaches TIMEOUT; consecutive-edge count cleared.
REQ-025 LOST -> LOCKING on next en_rise; entering LOST SHALL clear the prescale counter.
REQ-026 Edge and timeout in the same cycle: edge wins, counter clears, no transition to LOST.
REQ-027 locked SHALL be high only in LOCKED; lost only in LOST; both registered from state.
REQ-028 en_rise/en_fall/en_pre/edge_count SHALL operate in every FSM state.

Reset
REQ-029 reset_n low SHALL asynchronously clear sync chain, history flop, all counters, and set FSM to IDLE.
REQ-030 During and after reset until first edge: en_rise=0, en_fall=0, en_pre=0, locked=0, lost=0, edge_count=0.
REQ-031 Reset asserted mid-lock SHALL drop locked within the same reset assertion, no partial pulses on release.
REQ-032 Release SHALL not generate a spurious en_rise if clk_div is already high: history flop reloads from chain before detect (first detected edge needs chain to see 0 then 1).

Configuration
REQ-033 Macro CLOCK_ENABLE_SYNC_WATCHDOG_EN defined: idle counter, FSM, locked, lost and prescaler clear on LOST implemented per REQ-020..027.
REQ-034 Macro undefined: no watchdog logic; locked tied 1, lost tied 0, prescaler cleared only by reset_n.

Verification
REQ-035 Defaults, clk_div square wave period 34 clk_src cycles from reset -> en_rise/en_fall each one cycle, en_rise 3 cycles after sampled rise, edge_count=10 after 10 rises.
REQ-036 PRESCALE=16, 40 rises -> en_pre on rises 16 and 32 only, coincident with en_rise.
REQ-037 Watchdog enabled, 4 rises -> locked high after 4th; hold clk_div static 64 cycles -> lost=1, locked=0; next rise -> lost=0, locked after 4 more rises.
REQ-038 Edge on exactly the 64th idle cycle -> lost stays 0.
REQ-039 clk_div held high through reset release -> no en_rise; edge_count 0xFFFF plus one rise -> 0x0000.
REQ-040 Macro undefined, clk_div static 1000 cycles -> locked=1, lost=0 throughout.
